nmea_uart_rx: RTL and testbench
===============================

NMEA_UART_RX -- requirements
Module: nmea_uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, GPS serial bit rate.
REQ-003 SHALL have parameter MAX_LEN, default 82, maximum sentence body bytes held between '$' and '*'.
REQ-004 SHALL have port clk  in  1  system clock; one clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port rxd  in  1  GPS UART serial line (GPIO_0[34]), idle high, asynchronous to clk.
REQ-007 SHALL have port byte_valid  out  1  one-cycle pulse per correctly framed received byte.
REQ-008 SHALL have port byte_data  out  8  received byte, valid while byte_valid=1.
REQ-009 SHALL have port framing_err  out  1  one-cycle pulse when stop bit samples 0.
REQ-010 SHALL have port overflow  out  1  one-cycle pulse when body exceeds MAX_LEN.
REQ-011 SHALL have port overrun  out  1  one-cycle pulse when a byte is dropped in LOCK.
REQ-012 SHALL have port sent_valid  out  1  level: complete sentence held in buffer.
REQ-013 SHALL have port sent_ok  out  1  checksum match, valid while sent_valid=1.
REQ-014 SHALL have port sent_len  out  7  body byte count, valid while sent_valid=1.
REQ-015 SHALL have port sent_ack  in  1  consumer releases buffer; sampled only while sent_valid=1.
REQ-016 SHALL have port rd_addr  in  7  buffer read address.
REQ-017 SHALL have port rd_data  out  8  buffer byte at rd_addr, registered, one-cycle latency.

Function
REQ-018 SHALL pass rxd through a 2-flop synchronizer (reset value 1) before any use.
REQ-019 SHALL use bit period DIV = CLK_HZ/BAUD truncated (5208 at defaults).
REQ-020 UART SHALL have states U_IDLE, U_START, U_DATA, U_STOP.
REQ-021 U_IDLE -> U_START on synchronized falling edge; U_START waits DIV/2 cycles, then returns to U_IDLE if line is high (glitch), else enters U_DATA.
REQ-022 U_DATA SHALL sample 8 bits LSB first, one every DIV cycles; U_STOP samples after a further DIV cycles.
REQ-023 Stop=1: byte_valid pulses the cycle after the stop sample; stop=0: framing_err pulses instead, byte discarded; both -> U_IDLE.
REQ-024 Parser SHALL consume only byte_valid bytes; states P_IDLE, P_BODY, P_CK1, P_CK2, P_EOL, P_LOCK.
REQ-025 '$' in any state except P_LOCK -> P_BODY, len=0, checksum=0.
REQ-026 P_IDLE: all bytes other than '$' ignored.
REQ-027 P_BODY: '*' -> P_CK1; if len=MAX_LEN, any other byte pulses overflow -> P_IDLE; else store at buffer[len], checksum ^= byte, len++.
REQ-028 P_CK1/P_CK2: accept '0'-'9','A'-'F' as high/low nibble; any other byte -> P_IDLE with no flag.
REQ-029 P_CK2 valid digit -> P_EOL; P_EOL: '\r' ignored; '\n' sets sent_valid=1, sent_ok=(received==computed), sent_len=len -> P_LOCK; other byte -> P_IDLE.
REQ-030 P_LOCK: every byte_valid byte, including '$', pulses overrun and is dropped; buffer contents frozen.
REQ-031 sent_ack=1 in P_LOCK: sent_valid=0 next cycle -> P_IDLE; sent_ack outside P_LOCK ignored.
REQ-032 rd_data SHALL return buffer[rd_addr] one cycle after rd_addr; addresses >= sent_len return undefined data.
REQ-033 UART SHALL keep receiving in every parser state; buffer write and read may occur in the same cycle.

Reset
REQ-034 reset SHALL force U_IDLE, P_IDLE, synchronizer to 1, all counters/checksum/len to 0, all outputs to 0, within the same cycle, including mid-byte or mid-sentence.
REQ-035 Buffer RAM contents SHALL NOT require reset.

Verification
REQ-036 Send "$GPGGA*56\r\n" at 9600 baud -> 11 byte_valid pulses, sent_valid=1, sent_ok=1, sent_len=5; rd_addr=0 -> rd_data=0x47 next cycle.
REQ-037 Send "$GPGGA*57\r\n" -> sent_valid=1, sent_ok=0, sent_len=5.
REQ-038 Frame 0x41 with stop bit 0 -> one framing_err pulse, no byte_valid; rxd low 1000 cycles then high -> no byte_valid, no framing_err.
REQ-039 '$' + 83 body bytes 'A' -> one overflow pulse on the 83rd, no sent_valid; subsequent "$GPGGA*56\r\n" accepted normally.
REQ-040 Hold sent_ack=0 after REQ-036, send "$X*58\r\n" -> 7 overrun pulses, sent_len stays 5; pulse sent_ack -> sent_valid=0 next cycle.
REQ-041 Assert reset mid-sentence after "$GPG" -> outputs 0; after release "$GPGGA*56\r\n" -> sent_ok=1, sent_len=5.

Source files
------------

// File: rtl/nmea_uart_rx.sv
// NMEA-0183 receiver: 8N1 UART front end feeding a sentence parser that
// buffers the body between '$' and '*', verifies the XOR checksum and holds
// the completed sentence until the consumer acknowledges it.
module nmea_uart_rx #(
  parameter int CLK_HZ  = 50000000,
  parameter int BAUD    = 9600,
  parameter int MAX_LEN = 82
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       framing_err,
  output logic       overflow,
  output logic       overrun,
  output logic       sent_valid,
  output logic       sent_ok,
  output logic [6:0] sent_len,
  input  logic       sent_ack,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [6:0]    MAXL    = 7'(MAX_LEN);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} u_state_t;
  typedef enum logic [2:0] {P_IDLE, P_BODY, P_CK1, P_CK2, P_EOL, P_LOCK} p_state_t;

  // Returns {is_hex_digit, nibble}; only upper-case hex is legal in NMEA.
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    logic [7:0] t;
    t = 8'h00;
    if (c >= 8'h30 && c <= 8'h39) begin
      t = c - 8'h30;
      return {1'b1, t[3:0]};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      t = c - 8'h37;
      return {1'b1, t[3:0]};
    end
    return 5'b0_0000;
  endfunction

  // ---------------- synchronizer ----------------
  logic sync1_q, rxd_s, rxd_prev_q;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      rxd_s      <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rxd;
      rxd_s      <= sync1_q;
      rxd_prev_q <= rxd_s;
    end
  end

  // ---------------- UART ----------------
  u_state_t      u_state_q, u_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          bv_q, bv_d;
  logic [7:0]    bd_q, bd_d;
  logic          fe_q, fe_d;

  // UART state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      u_state_q <= U_IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      shreg_q   <= 8'h00;
      bv_q      <= 1'b0;
      bd_q      <= 8'h00;
      fe_q      <= 1'b0;
    end else begin
      u_state_q <= u_state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      bv_q      <= bv_d;
      bd_q      <= bd_d;
      fe_q      <= fe_d;
    end
  end

  // UART next state: mid-start check rejects glitches, then one sample per bit period.
  always_comb begin
    u_state_d = u_state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    bv_d      = 1'b0;
    bd_d      = bd_q;
    fe_d      = 1'b0;
    case (u_state_q)
      U_IDLE: begin
        cnt_d = '0;
        if (rxd_prev_q && !rxd_s) u_state_d = U_START;
      end
      U_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = 3'd0;
          u_state_d = rxd_s ? U_IDLE : U_DATA;
        end
      end
      U_DATA: begin
        if (cnt_q == DIV_M1) begin
          cnt_d   = '0;
          shreg_d = {rxd_s, shreg_q[7:1]};
          if (bit_q == 3'd7) u_state_d = U_STOP;
          else               bit_d = bit_q + 3'd1;
        end
      end
      U_STOP: begin
        if (cnt_q == DIV_M1) begin
          cnt_d     = '0;
          u_state_d = U_IDLE;
          if (rxd_s) begin
            bv_d = 1'b1;
            bd_d = shreg_q;
          end else begin
            fe_d = 1'b1;
          end
        end
      end
      default: u_state_d = U_IDLE;
    endcase
  end

  // ---------------- parser ----------------
  p_state_t   p_state_q, p_state_d;
  logic [6:0] len_q, len_d;
  logic [7:0] csum_q, csum_d;
  logic [7:0] ck_q, ck_d;
  logic       ovf_q, ovf_d;
  logic       ovr_q, ovr_d;
  logic       sv_q, sv_d;
  logic       ok_q, ok_d;
  logic [6:0] slen_q, slen_d;
  logic       we;
  logic [4:0] hx;
  logic [7:0] mem [128];
  logic [7:0] rd_data_q;

  // Parser state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_state_q <= P_IDLE;
      len_q     <= 7'd0;
      csum_q    <= 8'h00;
      ck_q      <= 8'h00;
      ovf_q     <= 1'b0;
      ovr_q     <= 1'b0;
      sv_q      <= 1'b0;
      ok_q      <= 1'b0;
      slen_q    <= 7'd0;
    end else begin
      p_state_q <= p_state_d;
      len_q     <= len_d;
      csum_q    <= csum_d;
      ck_q      <= ck_d;
      ovf_q     <= ovf_d;
      ovr_q     <= ovr_d;
      sv_q      <= sv_d;
      ok_q      <= ok_d;
      slen_q    <= slen_d;
    end
  end

  // Parser next state: LOCK freezes the buffer until acknowledged; '$' restarts elsewhere.
  always_comb begin
    p_state_d = p_state_q;
    len_d     = len_q;
    csum_d    = csum_q;
    ck_d      = ck_q;
    ovf_d     = 1'b0;
    ovr_d     = 1'b0;
    sv_d      = sv_q;
    ok_d      = ok_q;
    slen_d    = slen_q;
    we        = 1'b0;
    hx        = hex_nib(bd_q);
    if (p_state_q == P_LOCK) begin
      if (bv_q) ovr_d = 1'b1;
      if (sent_ack) begin
        sv_d      = 1'b0;
        p_state_d = P_IDLE;
      end
    end else if (bv_q) begin
      if (bd_q == 8'h24) begin
        p_state_d = P_BODY;
        len_d     = 7'd0;
        csum_d    = 8'h00;
      end else begin
        case (p_state_q)
          P_BODY: begin
            if (bd_q == 8'h2A) begin
              p_state_d = P_CK1;
            end else if (len_q == MAXL) begin
              ovf_d     = 1'b1;
              p_state_d = P_IDLE;
            end else begin
              we     = 1'b1;
              csum_d = csum_q ^ bd_q;
              len_d  = len_q + 7'd1;
            end
          end
          P_CK1: begin
            if (hx[4]) begin
              ck_d[7:4] = hx[3:0];
              p_state_d = P_CK2;
            end else begin
              p_state_d = P_IDLE;
            end
          end
          P_CK2: begin
            if (hx[4]) begin
              ck_d[3:0] = hx[3:0];
              p_state_d = P_EOL;
            end else begin
              p_state_d = P_IDLE;
            end
          end
          P_EOL: begin
            if (bd_q == 8'h0A) begin
              sv_d      = 1'b1;
              ok_d      = (ck_q == csum_q);
              slen_d    = len_q;
              p_state_d = P_LOCK;
            end else if (bd_q != 8'h0D) begin
              p_state_d = P_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Sentence body buffer; not reset, contents beyond sent_len are don't-care.
  always_ff @(posedge clk) begin
    if (we) mem[len_q] <= bd_q;
  end

  // Registered read port, one cycle latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data_q <= 8'h00;
    else       rd_data_q <= mem[rd_addr];
  end

  assign byte_valid  = bv_q;
  assign byte_data   = bd_q;
  assign framing_err = fe_q;
  assign overflow    = ovf_q;
  assign overrun     = ovr_q;
  assign sent_valid  = sv_q;
  assign sent_ok     = ok_q;
  assign sent_len    = slen_q;
  assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_nmea_uart_rx.sv
// Scoreboard bench for nmea_uart_rx: stimulus pushes expected events,
// a negedge monitor pops and compares whenever the DUT emits one.
`timescale 1ns/1ps
module tb_nmea_uart_rx;
  // Short bit period keeps the run small; glitch length scaled to match.
  localparam int CLK_HZ  = 1600000;
  localparam int BAUD    = 100000;
  localparam int DIV     = CLK_HZ / BAUD;
  localparam int MAX_LEN = 82;

  logic       clk = 1'b0, reset = 1'b1, rxd = 1'b1;
  logic       byte_valid, framing_err, overflow, overrun;
  logic       sent_valid, sent_ok, sent_ack = 1'b0;
  logic [7:0] byte_data, rd_data;
  logic [6:0] sent_len, rd_addr = 7'd0;

  nmea_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset(reset), .rxd(rxd),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .framing_err(framing_err), .overflow(overflow), .overrun(overrun),
    .sent_valid(sent_valid), .sent_ok(sent_ok), .sent_len(sent_len),
    .sent_ack(sent_ack), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic ok; logic [6:0] len; } sent_t;

  int         checks = 0, errors = 0;
  logic [7:0] exp_bytes[$];
  sent_t      exp_sent[$];
  int         exp_fe = 0, exp_ovf = 0, exp_ovr = 0;
  logic       sv_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got pulse expected none", name);
  endtask

  // Monitor: every DUT event must match a queued expectation.
  always @(negedge clk) begin
    logic [7:0] b;
    sent_t      s;
    if (reset) begin
      sv_prev = 1'b0;
    end else begin
      if (byte_valid) begin
        if (exp_bytes.size() == 0) unexpected("byte_valid");
        else begin
          b = exp_bytes.pop_front();
          check("byte_data", byte_data, b);
        end
      end
      if (framing_err) begin
        if (exp_fe == 0) unexpected("framing_err");
        else begin checks++; exp_fe--; end
      end
      if (overflow) begin
        if (exp_ovf == 0) unexpected("overflow");
        else begin checks++; exp_ovf--; end
      end
      if (overrun) begin
        if (exp_ovr == 0) unexpected("overrun");
        else begin checks++; exp_ovr--; end
      end
      if (sent_valid && !sv_prev) begin
        if (exp_sent.size() == 0) unexpected("sent_valid");
        else begin
          s = exp_sent.pop_front();
          check("sent_ok", sent_ok, s.ok);
          check("sent_len", sent_len, s.len);
        end
      end
      sv_prev = sent_valid;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0; idle(DIV);
    for (int i = 0; i < 8; i++) begin rxd = b[i]; idle(DIV); end
    rxd = stop; idle(DIV);
    rxd = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit locked);
    exp_bytes.push_back(b);
    if (locked) exp_ovr++;
    send_frame(b, 1'b1);
  endtask

  task automatic send_line(input string s, input bit locked);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], locked);
    send_byte(8'h0D, locked);
    send_byte(8'h0A, locked);
    idle(4);
  endtask

  task automatic expect_sent(input logic ok, input logic [6:0] len);
    sent_t s;
    s.ok = ok; s.len = len;
    exp_sent.push_back(s);
  endtask

  task automatic read_chk(input string name, input logic [6:0] a, input logic [7:0] exp);
    rd_addr = a;
    idle(1);
    check(name, rd_data, exp);
  endtask

  task automatic ack();
    sent_ack = 1'b1; idle(1);
    sent_ack = 1'b0; idle(1);
    check("sent_valid after ack", sent_valid, 1'b0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " byte_valid"}, byte_valid, 0);
    check({tag, " byte_data"}, byte_data, 0);
    check({tag, " framing_err"}, framing_err, 0);
    check({tag, " overflow"}, overflow, 0);
    check({tag, " overrun"}, overrun, 0);
    check({tag, " sent_valid"}, sent_valid, 0);
    check({tag, " sent_ok"}, sent_ok, 0);
    check({tag, " sent_len"}, sent_len, 0);
    check({tag, " rd_data"}, rd_data, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    check_zero_outputs("reset");
    reset = 1'b0;
    idle(5);

    // Good sentence, then buffer readback.
    expect_sent(1'b1, 7'd5);
    send_line("$GPGGA*56", 1'b0);
    check("sent_valid level", sent_valid, 1'b1);
    read_chk("rd_data[0]", 7'd0, 8'h47);
    read_chk("rd_data[1]", 7'd1, 8'h50);
    read_chk("rd_data[4]", 7'd4, 8'h41);

    // Held sentence: every new byte is an overrun, buffer stays frozen.
    send_line("$X*58", 1'b1);
    check("locked sent_valid", sent_valid, 1'b1);
    check("locked sent_len", sent_len, 7'd5);
    check("locked sent_ok", sent_ok, 1'b1);
    read_chk("frozen rd_data[0]", 7'd0, 8'h47);
    ack();

    // Checksum mismatch.
    expect_sent(1'b0, 7'd5);
    send_line("$GPGGA*57", 1'b0);
    ack();

    // '$' mid-body restarts the sentence.
    expect_sent(1'b1, 7'd5);
    send_line("$ZZ$GPGGA*56", 1'b0);
    ack();

    // Non-hex checksum digit abandons the sentence silently.
    send_line("$AB*G1", 1'b0);
    check("bad hex sent_valid", sent_valid, 1'b0);

    // Bad stop bit, then a start glitch shorter than half a bit.
    exp_fe++;
    send_frame(8'h41, 1'b0);
    idle(DIV);
    rxd = 1'b0; idle(5);
    rxd = 1'b1; idle(3 * DIV);

    // Body one byte too long.
    send_byte(8'h24, 1'b0);
    for (int i = 0; i < 83; i++) begin
      if (i == 82) exp_ovf++;
      send_byte(8'h41, 1'b0);
    end
    idle(4);
    check("overflow sent_valid", sent_valid, 1'b0);
    expect_sent(1'b1, 7'd5);
    send_line("$GPGGA*56", 1'b0);
    ack();

    // Body of exactly MAX_LEN bytes is accepted (even count of 'A' xors to 00).
    expect_sent(1'b1, 7'(MAX_LEN));
    send_byte(8'h24, 1'b0);
    for (int i = 0; i < MAX_LEN; i++) send_byte(8'h41, 1'b0);
    send_line("*00", 1'b0);
    read_chk("rd_data[last]", 7'(MAX_LEN - 1), 8'h41);
    ack();

    // Reset mid-sentence and mid-byte.
    for (int i = 0; i < 4; i++) begin
      logic [7:0] c;
      string      pre;
      pre = "$GPG";
      c = pre[i];
      send_byte(c, 1'b0);
    end
    rd_addr = 7'd0;
    rxd = 1'b0;
    idle(3 * DIV);
    reset = 1'b1;
    idle(1);
    check_zero_outputs("mid reset");
    rxd = 1'b1;
    reset = 1'b0;
    idle(2 * DIV);
    expect_sent(1'b1, 7'd5);
    send_line("$GPGGA*56", 1'b0);
    check("post reset sent_ok", sent_ok, 1'b1);
    check("post reset sent_len", sent_len, 7'd5);
    ack();

    idle(2 * DIV);
    check("pending bytes", exp_bytes.size(), 0);
    check("pending sentences", exp_sent.size(), 0);
    check("pending framing_err", exp_fe, 0);
    check("pending overflow", exp_ovf, 0);
    check("pending overrun", exp_ovr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
